// File: rtl/easyaxi_arb_pkg.sv
// Shared types and helpers for the easyaxi weighted round-robin arbiter.
// Holds the IDLE/GRANT state encoding and the index-width helper.
package easyaxi_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/easyaxi_rr_pick.sv
// Combinational wrap-around priority search: the first set req bit at or
// above ptr, wrapping from REQ_NUM-1 back to 0.
module easyaxi_rr_pick #(
  parameter int REQ_NUM = 8,
  parameter int IDX_W   = 3
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [REQ_NUM-1:0] oh,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Walk candidate offsets from ptr; j matches offset i directly or after wrap.
  always_comb begin
    oh  = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      for (int j = 0; j < REQ_NUM; j++) begin
        if (!any && req[j] &&
            ((j == int'(ptr) + i) || (j == int'(ptr) + i - REQ_NUM))) begin
          any   = 1'b1;
          idx   = IDX_W'(j);
          oh[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/easyaxi_wrr_arb.sv
// Weighted round-robin arbiter with registered grant outputs.
// A requester keeps priority for up to weight consecutive handshakes
// (weight 0 counts as 1) before the pointer moves past it.
// Optional feature: define EASYAXI_ARB_LOCK_EN to add lock_i, which pins
// the next grant on the requester just accepted while it keeps requesting.
module easyaxi_wrr_arb
  import easyaxi_arb_pkg::*;
#(
  parameter  int REQ_NUM  = 8,
  parameter  int WEIGHT_W = 4,
  localparam int IDX_W    = idx_w(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_NUM-1:0]           req_i,
  input  logic [REQ_NUM*WEIGHT_W-1:0]  weight_i,
  input  logic                         grant_ready_i,
`ifdef EASYAXI_ARB_LOCK_EN
  input  logic                         lock_i,
`endif
  output logic                         grant_valid_o,
  output logic [IDX_W-1:0]             grant_idx_o,
  output logic [REQ_NUM-1:0]           grant_oh_o
);

  arb_state_e            state;
  logic [IDX_W-1:0]      ptr;
  logic [WEIGHT_W-1:0]   cnt;

  logic                  hs;
  logic                  use_credit;
  logic [WEIGHT_W-1:0]   wsel;
  logic [WEIGHT_W-1:0]   w_eff;
  logic [WEIGHT_W:0]     used;
  logic [IDX_W-1:0]      ptr_inc;
  logic [IDX_W-1:0]      ptr_nxt;
  logic [WEIGHT_W-1:0]   cnt_nxt;

  logic [REQ_NUM-1:0]    pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;

  logic                  load;
  logic [IDX_W-1:0]      nxt_idx;
  logic [REQ_NUM-1:0]    nxt_oh;

  assign hs = grant_valid_o & grant_ready_i;

`ifdef EASYAXI_ARB_LOCK_EN
  logic                  sel_en;
  logic                  lock_flg;
  logic [IDX_W-1:0]      lock_idx;
  logic [REQ_NUM-1:0]    lock_oh;
  logic                  grant_locked;
  logic                  lock_flg_nxt;
  logic [IDX_W-1:0]      lock_idx_nxt;
  logic [REQ_NUM-1:0]    lock_oh_nxt;
  logic                  lock_hit;

  // A grant produced by the lock does not consume or move credits.
  assign use_credit = hs & ~grant_locked;
  assign sel_en     = (state == IDLE) | hs;

  // Lock target as seen by this cycle's selection (a handshake refreshes it).
  always_comb begin
    lock_flg_nxt = hs ? lock_i      : lock_flg;
    lock_idx_nxt = hs ? grant_idx_o : lock_idx;
    lock_oh_nxt  = hs ? grant_oh_o  : lock_oh;
    lock_hit     = sel_en & lock_flg_nxt & (|(req_i & lock_oh_nxt));
  end

  // Lock flag and target; the flag drops at any selection that misses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_flg     <= 1'b0;
      lock_idx     <= '0;
      lock_oh      <= '0;
      grant_locked <= 1'b0;
    end else begin
      if (sel_en) begin
        lock_flg     <= lock_hit;
        grant_locked <= lock_hit;
      end
      if (hs) begin
        lock_idx <= grant_idx_o;
        lock_oh  <= grant_oh_o;
      end
    end
  end

  // Next grant source: the locked requester wins over the round-robin pick.
  always_comb begin
    load    = lock_hit | pick_any;
    nxt_idx = lock_hit ? lock_idx_nxt : pick_idx;
    nxt_oh  = lock_hit ? lock_oh_nxt  : pick_oh;
  end
`else
  assign use_credit = hs;

  // Next grant source is always the round-robin pick.
  always_comb begin
    load    = pick_any;
    nxt_idx = pick_idx;
    nxt_oh  = pick_oh;
  end
`endif

  // Weight of the currently granted requester, selected by its one-hot.
  always_comb begin
    wsel = '0;
    for (int j = 0; j < REQ_NUM; j++) begin
      if (grant_oh_o[j]) wsel = weight_i[j*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Credit update for the handshake happening this cycle.
  always_comb begin
    w_eff   = (wsel == '0) ? WEIGHT_W'(1) : wsel;
    used    = (grant_idx_o == ptr) ? ({1'b0, cnt} + (WEIGHT_W+1)'(1))
                                   : (WEIGHT_W+1)'(1);
    ptr_inc = (int'(grant_idx_o) == REQ_NUM - 1) ? '0
                                                 : grant_idx_o + IDX_W'(1);
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    if (use_credit) begin
      if (used >= {1'b0, w_eff}) begin
        ptr_nxt = ptr_inc;
        cnt_nxt = '0;
      end else begin
        ptr_nxt = grant_idx_o;
        cnt_nxt = used[WEIGHT_W-1:0];
      end
    end
  end

  // Search runs from the pointer as updated by any handshake this cycle.
  easyaxi_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (req_i),
    .ptr (ptr_nxt),
    .oh  (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant FSM with registered outputs; a grant is held until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant_valid_o <= 1'b0;
      grant_idx_o   <= '0;
      grant_oh_o    <= '0;
      ptr           <= '0;
      cnt           <= '0;
    end else begin
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
      case (state)
        IDLE: begin
          if (load) begin
            state         <= GRANT;
            grant_valid_o <= 1'b1;
            grant_idx_o   <= nxt_idx;
            grant_oh_o    <= nxt_oh;
          end
        end
        GRANT: begin
          if (hs) begin
            if (load) begin
              grant_idx_o <= nxt_idx;
              grant_oh_o  <= nxt_oh;
            end else begin
              state         <= IDLE;
              grant_valid_o <= 1'b0;
              grant_oh_o    <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/easyaxi_wrr_arb.md
EASYAXI_WRR_ARB -- requirements
Module: easyaxi_wrr_arb

Interface
REQ-001 SHALL have parameter REQ_NUM, default 8, number of requesters (>=1).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-requester weight field.
REQ-003 SHALL derive IDX_W = max(1, clog2(REQ_NUM)).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_i  input  REQ_NUM  per-requester request, level.
REQ-007 SHALL have port weight_i  input  REQ_NUM*WEIGHT_W  weight of requester k in bits [k*WEIGHT_W +: WEIGHT_W].
REQ-008 SHALL have port grant_ready_i  input  1  downstream accepts the current grant.
REQ-009 SHALL have port grant_valid_o  output  1  a grant is presented.
REQ-010 SHALL have port grant_idx_o  output  IDX_W  index of the granted requester.
REQ-011 SHALL have port grant_oh_o  output  REQ_NUM  one-hot form of grant_idx_o; all zeros when grant_valid_o=0.
REQ-012 SHALL have port lock_i  input  1  hold the grant on the same requester; present only under EASYAXI_ARB_LOCK_EN.

Function
REQ-013 SHALL register all outputs; there is no combinational path from input to output.
REQ-014 SHALL implement the two states IDLE (grant_valid_o=0) and GRANT (grant_valid_o=1).
REQ-015 In IDLE with |req_i=1, the block SHALL enter GRANT on the next edge with the selected index, giving 1-cycle latency; with req_i=0 it SHALL stay in IDLE.
REQ-016 Selection SHALL pick the first set req_i bit, searching upward from priority pointer ptr and wrapping past REQ_NUM-1 to 0.
REQ-017 In GRANT with grant_ready_i=0, grant_idx_o and grant_oh_o SHALL stay stable regardless of req_i or weight_i changes, and the grant SHALL never be retracted.
REQ-018 A handshake is grant_valid_o & grant_ready_i; on a handshake with |req_i=1, the next grant SHALL load on the same edge (back-to-back, one grant per cycle); with req_i=0 the block SHALL return to IDLE.
REQ-019 The next selection after a handshake SHALL use the ptr value updated by that handshake.
REQ-020 Credits: on a handshake of index k, used = (k==ptr) ? cnt+1 : 1, and w = max(weight_i[k],1), with weight 0 treated as 1; weights are sampled at the handshake.
REQ-021 If used >= w, the block SHALL set ptr <= (k+1) mod REQ_NUM and cnt <= 0; otherwise ptr <= k and cnt <= used.
REQ-022 cnt SHALL be WEIGHT_W bits wide and SHALL never exceed 2^WEIGHT_W-1.
REQ-023 For REQ_NUM=1, grant_idx_o SHALL stay 0 and credits SHALL have no observable effect.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set state IDLE, grant_valid_o=0, grant_idx_o=0, grant_oh_o=0, ptr=0, cnt=0 and lock flag=0.
REQ-025 Reset asserted mid-grant SHALL abandon the grant without a handshake; the first grant after reset SHALL search from index 0.

Configuration
REQ-026 Macro EASYAXI_ARB_LOCK_EN, when defined, SHALL add lock_i: a handshake with lock_i=1 sets a lock flag for the granted index k.
REQ-027 With the lock flag set and req_i[k]=1, the next selection SHALL be k, and that grant SHALL leave ptr/cnt unchanged.
REQ-028 With the lock flag set and req_i[k]=0, the block SHALL clear the flag and use normal selection.
REQ-029 A handshake with lock_i=0 SHALL clear the flag.
REQ-030 Without EASYAXI_ARB_LOCK_EN, lock_i and the lock flag SHALL be absent and behaviour SHALL be pure weighted round-robin.

Structure
REQ-031 Package easyaxi_arb_pkg SHALL hold the IDLE/GRANT state encoding and the IDX_W width helper function.
REQ-032 Sub-module easyaxi_rr_pick SHALL implement the purely combinational wrap-around priority search (req, ptr -> one-hot, index, any).
REQ-033 easyaxi_wrr_arb SHALL hold the state, credit and lock registers.

Verification (REQ_NUM=4, WEIGHT_W=4)
REQ-034 The bench SHALL cover: after reset, req=0000 for 3 cycles -> valid=0; then req=1010 -> next cycle valid=1, idx=1, oh=0010.
REQ-035 The bench SHALL cover: weights 1,1,1,1, req=1111, ready=1 -> idx sequence 0,1,2,3,0, one per cycle.
REQ-036 The bench SHALL cover: weight[0]=3 and others 1 (also weight[2]=0), req=1111, ready=1 -> idx 0,0,0,1,2,3,0.
REQ-037 The bench SHALL cover: grant idx=1 with ready=0 for 5 cycles while req changes to 0100 -> idx=1 and oh=0010 stable; then ready=1 -> next idx=2.
REQ-038 The bench SHALL cover (with EASYAXI_ARB_LOCK_EN): idx=1 accepted with lock_i=1, req=1111 -> next idx=1 and ptr unchanged; then lock_i=0 -> idx=2.
REQ-039 The bench SHALL cover: rst=1 for 1 cycle while valid=1, idx=2 -> next cycle valid=0; with req=1111, the first grant is idx=0.
